// File: rtl/display_timing_if.sv
// -----------------------------------------------------------------------------
// display_timing_if
//
// Purpose: groups the count enable and all raster timing outputs of the
//          display timing generator into one bundle.
//
// Signals:
//   en          - count enable; 0 freezes every counter
//   hCount      - current column
//   vCount      - current line
//   hSync       - horizontal sync, active low
//   vSync       - vertical sync, active low
//   bright      - high inside the visible window
//   pixel_en    - one-clk pixel strobe
//   line_tick   - one-clk pulse on the last pixel of a line
//   frame_tick  - one-clk pulse on the last pixel of a frame
//   frame_count - frames completed, modulo 256
//
// Modports:
//   master - the timing generator (drives timing, receives en)
//   slave  - a consumer of the timing (drives en, receives timing)
// -----------------------------------------------------------------------------
interface display_timing_if;
    logic       en;
    logic [9:0] hCount;
    logic [9:0] vCount;
    logic       hSync;
    logic       vSync;
    logic       bright;
    logic       pixel_en;
    logic       line_tick;
    logic       frame_tick;
    logic [7:0] frame_count;

    modport master (
        input  en,
        output hCount, vCount, hSync, vSync, bright,
        output pixel_en, line_tick, frame_tick, frame_count
    );

    modport slave (
        output en,
        input  hCount, vCount, hSync, vSync, bright,
        input  pixel_en, line_tick, frame_tick, frame_count
    );
endinterface

// File: rtl/display_timing.sv
// -----------------------------------------------------------------------------
// display_timing
//
// Purpose: raster timing generator for a VGA-style display. A clock divider
//          produces a pixel strobe; column and line counters advance on that
//          strobe and the sync, visible-window and tick outputs are decoded
//          from the registered counters.
//
// Ports:
//   clk - system clock
//   rst - synchronous, active-high reset
//   tim - display_timing_if master modport (en in, all timing outputs out)
//
// Parameters:
//   CLK_DIV                  - clk cycles per pixel
//   H_TOTAL / V_TOTAL        - pixels per line / lines per frame
//   H_SYNC / V_SYNC          - sync low width in pixels / lines
//   H_ACT_START / H_ACT_END  - visible columns [start, end)
//   V_ACT_START / V_ACT_END  - visible lines   [start, end)
// -----------------------------------------------------------------------------
module display_timing #(
    parameter int CLK_DIV     = 4,
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int H_ACT_START = 144,
    parameter int H_ACT_END   = 784,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter int V_ACT_START = 35,
    parameter int V_ACT_END   = 515
) (
    input  logic               clk,
    input  logic               rst,
    display_timing_if.master   tim
);

    // A divide-by-one still needs a one-bit register so the width never collapses.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0]       H_SYNC_W  = 10'(H_SYNC);
    localparam logic [9:0]       V_SYNC_W  = 10'(V_SYNC);
    localparam logic [9:0]       H_VIS_LO  = 10'(H_ACT_START);
    localparam logic [9:0]       H_VIS_HI  = 10'(H_ACT_END);
    localparam logic [9:0]       V_VIS_LO  = 10'(V_ACT_START);
    localparam logic [9:0]       V_VIS_HI  = 10'(V_ACT_END);

    logic [DIV_W-1:0] div_q,        div_d;
    logic [9:0]       hCount_q,     hCount_d;
    logic [9:0]       vCount_q,     vCount_d;
    logic [7:0]       frameCount_q, frameCount_d;

    logic pixelEn;
    logic lineEnd;
    logic frameEnd;

    // Strobes are decoded from the pre-increment counters. Gating them with rst
    // means a reset landing on the last pixel of a frame never emits a
    // frame_tick and never bumps the frame counter.
    always_comb begin
        pixelEn  = tim.en && !rst && (div_q == DIV_LAST);
        lineEnd  = pixelEn && (hCount_q == H_LAST);
        frameEnd = lineEnd && (vCount_q == V_LAST);
    end

    // Next-state logic. Each counter wraps at its last legal value so no
    // register ever holds a value at or above its total.
    always_comb begin
        div_d        = div_q;
        hCount_d     = hCount_q;
        vCount_d     = vCount_q;
        frameCount_d = frameCount_q;

        if (tim.en) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
            end else begin
                div_d = div_q + 1'b1;
            end
        end

        if (pixelEn) begin
            if (hCount_q == H_LAST) begin
                hCount_d = '0;
            end else begin
                hCount_d = hCount_q + 10'd1;
            end
        end

        if (lineEnd) begin
            if (vCount_q == V_LAST) begin
                vCount_d = '0;
            end else begin
                vCount_d = vCount_q + 10'd1;
            end
        end

        if (frameEnd) begin
            frameCount_d = frameCount_q + 8'd1;
        end
    end

    // State registers; reset wins over enable and over any wrap in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q        <= '0;
            hCount_q     <= '0;
            vCount_q     <= '0;
            frameCount_q <= '0;
        end else begin
            div_q        <= div_d;
            hCount_q     <= hCount_d;
            vCount_q     <= vCount_d;
            frameCount_q <= frameCount_d;
        end
    end

    // Sync and visible-window decode follow the registered counters directly,
    // so they stay aligned with hCount/vCount and keep tracking while en=0.
    // Forcing them low during reset keeps the outputs quiet before the first
    // reset edge has cleared the counters.
    always_comb begin
        tim.hCount      = hCount_q;
        tim.vCount      = vCount_q;
        tim.frame_count = frameCount_q;
        tim.pixel_en    = pixelEn;
        tim.line_tick   = lineEnd;
        tim.frame_tick  = frameEnd;
        tim.hSync       = !rst && (hCount_q >= H_SYNC_W);
        tim.vSync       = !rst && (vCount_q >= V_SYNC_W);
        tim.bright      = !rst
                          && (hCount_q >= H_VIS_LO) && (hCount_q < H_VIS_HI)
                          && (vCount_q >= V_VIS_LO) && (vCount_q < V_VIS_HI);
    end

endmodule

// File: tb/tb_display_timing.sv
// -----------------------------------------------------------------------------
// tb_display_timing
//
// Purpose: directed self-checking bench for display_timing. One instance uses
//          the default 800x525 geometry for the divider, line-wrap, sync and
//          enable-freeze behaviour; a second, scaled-down instance makes whole
//          frames short enough to sweep for frame ticks and the visible window.
//
// Scaled geometry (CLK_DIV=2): 20 pixels x 12 lines, hSync low 0..2,
// vSync low 0..1, visible columns 5..16, visible lines 3..9 -> 12x7 = 84.
// -----------------------------------------------------------------------------
module tb_display_timing;

    localparam int S_DIV     = 2;
    localparam int S_HTOT    = 20;
    localparam int S_VTOT    = 12;
    localparam int S_FRAME   = S_DIV * S_HTOT * S_VTOT;

    logic clk;
    logic rst;
    logic en;

    int checks;
    int passes;

    display_timing_if ifDef ();
    display_timing_if ifSml ();

    assign ifDef.en = en;
    assign ifSml.en = en;

    display_timing dutDef (
        .clk (clk),
        .rst (rst),
        .tim (ifDef)
    );

    display_timing #(
        .CLK_DIV     (S_DIV),
        .H_TOTAL     (S_HTOT),
        .H_SYNC      (3),
        .H_ACT_START (5),
        .H_ACT_END   (17),
        .V_TOTAL     (S_VTOT),
        .V_SYNC      (2),
        .V_ACT_START (3),
        .V_ACT_END   (10)
    ) dutSml (
        .clk (clk),
        .rst (rst),
        .tim (ifSml)
    );

    // 100 MHz system clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed == expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drive reset/enable away from the rising edge and let combinational outputs settle.
    task automatic applyStimulus(input logic r, input logic e);
        rst = r;
        en  = e;
        #1;
    endtask

    // Advance one clock; outputs are sampled just after the falling edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Step the default instance until it shows column h (bounded).
    task automatic waitDefH(input int h, input int budget, output bit found);
        int n;
        n = 0;
        while ((int'(ifDef.hCount) != h) && (n < budget)) begin
            tick(1);
            n++;
        end
        found = (int'(ifDef.hCount) == h);
    endtask

    // Step the scaled instance until it shows (h, v), optionally on a strobe cycle.
    task automatic waitSml(input int h, input int v, input bit needPix,
                           input int budget, output bit found);
        int n;
        n = 0;
        found = 1'b0;
        while (n < budget) begin
            if ((int'(ifSml.hCount) == h) && (int'(ifSml.vCount) == v)
                && (!needPix || ifSml.pixel_en)) begin
                found = 1'b1;
                break;
            end
            tick(1);
            n++;
        end
    endtask

    initial begin
        bit   found;
        int   strobes;
        int   ticks;
        int   savedH;
        int   savedV;
        int   brightCnt;
        int   pixCnt;
        int   vsyncLowPix;
        int   vsyncBad;
        int   ftH;
        int   ftV;

        checks = 0;
        passes = 0;
        rst    = 1'b1;
        en     = 1'b0;

        // ---------------- Reset state (default geometry) ----------------
        tick(2);
        checkOutput("rst_hCount",   int'(ifDef.hCount),      0);
        checkOutput("rst_vCount",   int'(ifDef.vCount),      0);
        checkOutput("rst_frameCnt", int'(ifDef.frame_count), 0);
        checkOutput("rst_pixel_en", int'(ifDef.pixel_en),    0);
        checkOutput("rst_hSync",    int'(ifDef.hSync),       0);
        checkOutput("rst_vSync",    int'(ifDef.vSync),       0);
        checkOutput("rst_bright",   int'(ifDef.bright),      0);

        // ---------------- Divider: strobes on clk 4 and clk 8 ----------------
        applyStimulus(1'b0, 1'b1);
        strobes = 0;
        for (int k = 1; k <= 8; k++) begin
            if (ifDef.pixel_en) begin
                strobes++;
                checkOutput($sformatf("strobe_clk%0d", k), k, (k <= 4) ? 4 : 8);
            end
            tick(1);
        end
        checkOutput("div_strobes",  strobes,            2);
        checkOutput("div_hCount",   int'(ifDef.hCount), 2);

        // ---------------- End of line 0 ----------------
        begin
            int n;
            n = 0;
            while (!(ifDef.pixel_en && int'(ifDef.hCount) == 799) && n < 4000) begin
                tick(1);
                n++;
            end
            checkOutput("reach_h799", n < 4000, 1);
        end
        checkOutput("eol_vCount",     int'(ifDef.vCount),     0);
        checkOutput("eol_line_tick",  int'(ifDef.line_tick),  1);
        checkOutput("eol_frame_tick", int'(ifDef.frame_tick), 0);
        tick(1);
        checkOutput("nl_line_tick", int'(ifDef.line_tick), 0);
        checkOutput("nl_hCount",    int'(ifDef.hCount),    0);
        checkOutput("nl_vCount",    int'(ifDef.vCount),    1);
        checkOutput("nl_hSync_h0",  int'(ifDef.hSync),     0);
        waitDefH(95, 500, found);
        checkOutput("reach_h95",    found,                 1);
        checkOutput("hSync_h95",    int'(ifDef.hSync),     0);
        waitDefH(96, 500, found);
        checkOutput("reach_h96",    found,                 1);
        checkOutput("hSync_h96",    int'(ifDef.hSync),     1);

        // ---------------- Enable freeze at divider phase 2 ----------------
        begin
            int n;
            n = 0;
            while (!ifDef.pixel_en && n < 8) begin
                tick(1);
                n++;
            end
            checkOutput("reach_strobe", int'(ifDef.pixel_en), 1);
        end
        tick(3);
        savedH = int'(ifDef.hCount);
        savedV = int'(ifDef.vCount);
        applyStimulus(1'b0, 1'b0);
        strobes = 0;
        for (int k = 0; k < 10; k++) begin
            strobes += int'(ifDef.pixel_en) + int'(ifDef.line_tick) + int'(ifDef.frame_tick);
            tick(1);
        end
        checkOutput("hold_strobes", strobes,            0);
        checkOutput("hold_hCount",  int'(ifDef.hCount), savedH);
        checkOutput("hold_vCount",  int'(ifDef.vCount), savedV);
        checkOutput("hold_hSync",   int'(ifDef.hSync),  1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("resume_pix_c0", int'(ifDef.pixel_en), 0);
        tick(1);
        checkOutput("resume_pix_c1", int'(ifDef.pixel_en), 1);
        checkOutput("resume_hCount", int'(ifDef.hCount),   savedH);

        // ---------------- Full frame sweep (scaled geometry) ----------------
        applyStimulus(1'b1, 1'b1);
        tick(2);
        checkOutput("srst_frameCnt", int'(ifSml.frame_count), 0);
        checkOutput("srst_vSync",    int'(ifSml.vSync),       0);
        applyStimulus(1'b0, 1'b1);
        ticks       = 0;
        brightCnt   = 0;
        pixCnt      = 0;
        vsyncLowPix = 0;
        vsyncBad    = 0;
        ftH         = -1;
        ftV         = -1;
        for (int k = 1; k <= S_FRAME; k++) begin
            if (ifSml.frame_tick) begin
                ticks++;
                ftH = int'(ifSml.hCount);
                ftV = int'(ifSml.vCount);
            end
            if (ifSml.pixel_en) begin
                pixCnt++;
                if (ifSml.bright) brightCnt++;
                if (!ifSml.vSync) vsyncLowPix++;
            end
            if ((ifSml.vSync == 1'b0) != (int'(ifSml.vCount) < 2)) vsyncBad++;
            tick(1);
        end
        checkOutput("frame_ticks",    ticks,                   1);
        checkOutput("frame_tick_h",   ftH,                     S_HTOT - 1);
        checkOutput("frame_tick_v",   ftV,                     S_VTOT - 1);
        checkOutput("frame_pixels",   pixCnt,                  S_HTOT * S_VTOT);
        checkOutput("frame_bright",   brightCnt,               84);
        checkOutput("vsync_low_pix",  vsyncLowPix,             2 * S_HTOT);
        checkOutput("vsync_bad_cyc",  vsyncBad,                0);
        checkOutput("frame_end_h",    int'(ifSml.hCount),      0);
        checkOutput("frame_end_v",    int'(ifSml.vCount),      0);
        checkOutput("frame_count_1",  int'(ifSml.frame_count), 1);

        // ---------------- Visible-window edges (scaled geometry) ----------------
        waitSml(5, 2, 1'b0, 600, found);
        checkOutput("at_5_2",      found,              1);
        checkOutput("bright_5_2",  int'(ifSml.bright), 0);
        waitSml(4, 3, 1'b0, 600, found);
        checkOutput("at_4_3",      found,              1);
        checkOutput("bright_4_3",  int'(ifSml.bright), 0);
        waitSml(5, 3, 1'b0, 600, found);
        checkOutput("at_5_3",      found,              1);
        checkOutput("bright_5_3",  int'(ifSml.bright), 1);
        waitSml(17, 3, 1'b0, 600, found);
        checkOutput("at_17_3",     found,              1);
        checkOutput("bright_17_3", int'(ifSml.bright), 0);
        waitSml(16, 9, 1'b0, 600, found);
        checkOutput("at_16_9",     found,              1);
        checkOutput("bright_16_9", int'(ifSml.bright), 1);
        waitSml(5, 10, 1'b0, 600, found);
        checkOutput("at_5_10",     found,              1);
        checkOutput("bright_5_10", int'(ifSml.bright), 0);

        // ---------------- Reset on the final pixel of a frame ----------------
        applyStimulus(1'b1, 1'b1);
        tick(1);
        applyStimulus(1'b0, 1'b1);
        waitSml(S_HTOT - 1, S_VTOT - 1, 1'b1, 600, found);
        checkOutput("at_last_pix", found, 1);
        applyStimulus(1'b1, 1'b1);
        checkOutput("lastrst_frame_tick", int'(ifSml.frame_tick), 0);
        checkOutput("lastrst_line_tick",  int'(ifSml.line_tick),  0);
        checkOutput("lastrst_hSync",      int'(ifSml.hSync),      0);
        tick(1);
        checkOutput("lastrst_hCount",   int'(ifSml.hCount),      0);
        checkOutput("lastrst_vCount",   int'(ifSml.vCount),      0);
        checkOutput("lastrst_frameCnt", int'(ifSml.frame_count), 0);
        applyStimulus(1'b0, 1'b1);
        tick(1);
        checkOutput("after_frameCnt",   int'(ifSml.frame_count), 0);
        checkOutput("after_hCount",     int'(ifSml.hCount),      0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
